// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time program loader. Takes a byte stream (16-bit
//                big-endian word count, then big-endian 32-bit instruction
//                words), writes each word to instruction memory at its byte
//                address, and holds the CPU in reset until loading ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    // Memory capacity in words; 17 bits so that DEPTH = 65536 is representable.
    localparam logic [16:0] c_DEPTH = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [15:0]             r_len;
    logic [1:0]              r_byte_cnt;
    logic [ADDR_WIDTH-1:0]   r_word_index;
    logic [23:0]             r_shift;
    logic                    r_we;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic [15:0]             r_words_loaded;
    logic                    r_done_seen;

    logic                    w_accept;
    logic                    w_xfer;
    logic [15:0]             w_len_full;
    logic                    w_last_word;
    logic                    w_word_xfer;
    logic                    w_restart;

    assign w_accept    = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
    assign w_xfer      = in_valid && w_accept;
    assign w_len_full  = {r_len[15:8], in_data};
    // In DATA the length is at least 1, so LEN-1 cannot underflow.
    assign w_last_word = (r_words_loaded == (r_len - 16'd1));
    assign w_word_xfer = w_xfer && (r_state == DATA) && (r_byte_cnt == 2'd3);
    // start is honoured only outside an active session.
    assign w_restart   = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));

    assign in_ready     = w_accept;
    assign busy         = w_accept;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign words_loaded = r_words_loaded;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_next    = r_state;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (r_state)
            IDLE: begin
                if (start) w_next = LEN_HI;
            end
            LEN_HI: begin
                if (w_xfer) w_next = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0) begin
                        w_next = DONE;
                    end else if ({1'b0, w_len_full} > c_DEPTH) begin
                        w_next = ERROR;
                    end else begin
                        w_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_word_xfer && w_last_word) w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                // First DONE cycle may carry the final write; release the CPU after it.
                cpu_reset = !r_done_seen;
                if (start) w_next = LEN_HI;
            end
            ERROR: begin
                error = 1'b1;
                if (start) w_next = LEN_HI;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: length capture, word assembly and the registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len          <= 16'd0;
            r_byte_cnt     <= 2'd0;
            r_word_index   <= '0;
            r_shift        <= 24'd0;
            r_we           <= 1'b0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_words_loaded <= 16'd0;
            r_done_seen    <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_done_seen <= (r_state == DONE);
            if (w_restart) begin
                r_words_loaded <= 16'd0;
                r_word_index   <= '0;
                r_byte_cnt     <= 2'd0;
            end
            if (w_xfer) begin
                case (r_state)
                    LEN_HI: begin
                        r_len[15:8] <= in_data;
                    end
                    LEN_LO: begin
                        r_len[7:0]   <= in_data;
                        r_byte_cnt   <= 2'd0;
                        r_word_index <= '0;
                    end
                    DATA: begin
                        r_shift    <= {r_shift[15:0], in_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_we           <= 1'b1;
                            r_addr         <= 32'({r_word_index, 2'b00});
                            r_wdata        <= {r_shift, in_data};
                            r_words_loaded <= r_words_loaded + 16'd1;
                            // Wraps only after the final word of a full-depth load.
                            r_word_index   <= r_word_index + ADDR_WIDTH'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Load sessions are
//                checked against a stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    bit          wr_done_q[$];
    int          hs_cyc_q[$];
    int          rise_q[$];
    int          fall_q[$];

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle: memory writes, handshakes, done/cpu_reset edges.
    always @(negedge clk) begin : mon
        static bit prev_done = 1'b0;
        static bit prev_cpu  = 1'b1;
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            wr_cyc_q.push_back(cyc);
            wr_done_q.push_back(done);
        end
        if (in_valid && in_ready) hs_cyc_q.push_back(cyc);
        if (done && !prev_done) rise_q.push_back(cyc);
        if (!cpu_reset && prev_cpu) fall_q.push_back(cyc);
        prev_done = done;
        prev_cpu  = cpu_reset;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int stall_max, input bit inj);
        int ns;
        int t;
        ns = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
        for (int k = 0; k < ns; k++) begin
            in_valid = 1'b0;
            start    = inj && ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("hs_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        check_eq("start_done", {31'd0, done}, 32'd0);
        check_eq("start_error", {31'd0, error}, 32'd0);
        check_eq("start_words", {16'd0, words_loaded}, 32'd0);
    endtask

    // One complete session, checked against a stream-level model.
    task automatic run_session(input logic [7:0] b[$], input int stall_max,
                               input bit inject_start, input bit timing_chk);
        int len;
        bit eerr;
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        int wb, hb, rb, fb, nw;
        len  = int'(b[0]) * 256 + int'(b[1]);
        eerr = (len > DEPTH);
        if (!eerr) begin
            for (int w = 0; w < len; w++) begin
                ea.push_back(32'(w * 4));
                ed.push_back({b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]});
            end
        end
        wb = wr_addr_q.size();
        hb = hs_cyc_q.size();
        rb = rise_q.size();
        fb = fall_q.size();
        pulse_start();
        for (int i = 0; i < b.size(); i++)
            send_byte(b[i], stall_max, inject_start && (i >= 3) && !eerr);
        // Offer bytes after the session ends; none may be accepted.
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        repeat (4) @(negedge clk);
        check_eq("post_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        nw = wr_addr_q.size() - wb;
        check_eq("write_count", 32'(nw), 32'(ea.size()));
        for (int w = 0; w < ea.size() && w < nw; w++) begin
            check_eq("write_addr", wr_addr_q[wb+w], ea[w]);
            check_eq("write_data", wr_data_q[wb+w], ed[w]);
            check_eq("write_done_flag", {31'd0, wr_done_q[wb+w]}, {31'd0, (w == len - 1)});
        end
        check_eq("final_done", {31'd0, done}, {31'd0, !eerr});
        check_eq("final_error", {31'd0, error}, {31'd0, eerr});
        check_eq("final_busy", {31'd0, busy}, 32'd0);
        check_eq("final_words", {16'd0, words_loaded}, eerr ? 32'd0 : 32'(len));
        check_eq("final_cpu_reset", {31'd0, cpu_reset}, {31'd0, eerr});
        if (!eerr) begin
            check_eq("done_rise_seen", 32'(rise_q.size() - rb), 32'd1);
            check_eq("cpu_fall_seen", 32'(fall_q.size() - fb), 32'd1);
            if (rise_q.size() > rb && fall_q.size() > fb)
                check_eq("cpu_fall_delay", 32'(fall_q[fb] - rise_q[rb]), 32'd1);
        end
        if (timing_chk && nw >= 2 && hs_cyc_q.size() >= hb + 6) begin
            check_eq("first_write_lat", 32'(wr_cyc_q[wb] - hs_cyc_q[hb+5]), 32'd1);
            check_eq("write_gap", 32'(wr_cyc_q[wb+1] - wr_cyc_q[wb]), 32'd4);
        end
    endtask

    initial begin : stim
        logic [7:0] q[$];
        int len, r, wb;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("rst_we", {31'd0, imem_we}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_wdata", imem_wdata, 32'd0);
        check_eq("rst_words", {16'd0, words_loaded}, 32'd0);
        check_eq("rst_flags", {28'd0, busy, done, error, in_ready}, 32'd0);
        reset = 1'b0;
        // Bytes offered in IDLE are refused.
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (2) @(negedge clk);
        check_eq("idle_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        // Two-word program, no stalls, timing checked.
        q = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        run_session(q, 0, 1'b0, 1'b1);
        // Same program with stalls and ignored start pulses.
        run_session(q, 5, 1'b1, 1'b0);
        // Empty program.
        q = '{8'h00, 8'h00};
        run_session(q, 0, 1'b0, 1'b0);
        // Over-capacity lengths, then a full-depth load.
        q = '{8'h00, 8'h05};
        run_session(q, 0, 1'b0, 1'b0);
        q = '{8'h01, 8'h00};
        run_session(q, 2, 1'b0, 1'b0);
        q = '{8'h00, 8'h04};
        for (int i = 0; i < 16; i++) q.push_back(8'(i * 17 + 3));
        run_session(q, 0, 1'b0, 1'b0);

        // Reset in the middle of a three-word load.
        wb = wr_addr_q.size();
        pulse_start();
        q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        for (int i = 0; i < q.size(); i++) send_byte(q[i], 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_writes", 32'(wr_addr_q.size() - wb), 32'd1);
        if (wr_data_q.size() > wb) check_eq("mid_rst_data", wr_data_q[wb], 32'h12345678);
        check_eq("mid_rst_addr", imem_addr, 32'd0);
        check_eq("mid_rst_wdata", imem_wdata, 32'd0);
        check_eq("mid_rst_flags", {27'd0, imem_we, busy, done, error, in_ready}, 32'd0);
        check_eq("mid_rst_cpu", {31'd0, cpu_reset}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_quiet", 32'(wr_addr_q.size() - wb), 32'd1);
        q = '{8'h00, 8'h03};
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        run_session(q, 1, 1'b0, 1'b0);
        // Reload a single zero word after DONE.
        q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        run_session(q, 0, 1'b0, 1'b0);

        // Randomized sessions.
        for (int it = 0; it < 25; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      len = 0;
            else if (r <= 6) len = int'($urandom_range(1, DEPTH));
            else if (r == 7) len = DEPTH + int'($urandom_range(1, 3));
            else if (r == 8) len = 256 * int'($urandom_range(1, 255)) + int'($urandom_range(0, 255));
            else             len = DEPTH;
            q = '{8'(len >> 8), 8'(len)};
            if (len <= DEPTH)
                for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
            run_session(q, int'($urandom_range(0, 5)), 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the single-cycle CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at the PC-compatible byte address.
- Holds the CPU in reset until the whole program is loaded.

Parameters:
- ADDR_WIDTH, 8, number of word-address bits. Capacity DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load session.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  loader can accept a byte. A byte transfers when in_valid and in_ready are both high at a rising edge.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the word being written: word_index*4, so bits [1:0] are always 0.
- imem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  drives the CPU's reset input.
- busy  out  1  session in progress.
- done  out  1  program loaded.
- error  out  1  length header exceeded DEPTH.
- words_loaded  out  16  count of words written in the current session.

Behaviour:
- Reset values: state IDLE; cpu_reset=1; all other outputs 0 (imem_addr=0, imem_wdata=0, words_loaded=0).
- Reset asserted mid-session aborts the session immediately: no further imem_we, and all outputs return to their reset values.
- Stream format:
  - Byte 0 = LEN[15:8], byte 1 = LEN[7:0].
  - Then 4*LEN instruction bytes, most-significant byte first. The first data byte lands in imem_wdata[31:24].
- States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR.
- in_ready=1 only in LEN_HI, LEN_LO and DATA. busy=1 in exactly the same states.
- IDLE:
  - start moves to LEN_HI.
  - Bytes offered in IDLE are not accepted (in_ready=0).
- LEN_HI: on transfer, capture LEN[15:8] and move to LEN_LO.
- LEN_LO: on transfer, capture LEN[7:0], then:
  - LEN=0: go to DONE.
  - LEN>DEPTH: go to ERROR.
  - Otherwise: go to DATA with byte_cnt=0 and word_index=0.
- DATA:
  - Each transfer shifts the byte into the assembly register and increments byte_cnt (0..3, wraps to 0).
  - On the transfer with byte_cnt=3, the next cycle presents imem_we=1, imem_addr=word_index*4 and the complete word on imem_wdata.
  - In that same next cycle, words_loaded and word_index increment.
  - Write latency is 1 cycle after the 4th byte handshake.
  - If the completed word is word LEN-1, the state goes to DONE in the same cycle imem_we is high. Otherwise it stays in DATA; in_ready remains 1, so back-to-back bytes are accepted with no bubbles.
- imem_we is high for exactly one cycle per word and never high outside those cycles.
- Input stalls (in_valid=0) hold all state; a partial word is retained indefinitely.
- DONE:
  - done=1 from the first DONE cycle.
  - cpu_reset=1 during the first DONE cycle (the final write commits at its end); cpu_reset=0 from the second DONE cycle onward.
  - Stays in DONE until reset or start.
- ERROR: error=1, cpu_reset=1, no memory writes. Stays until reset or start.
- start in DONE or ERROR:
  - Moves to LEN_HI and re-asserts cpu_reset in the next cycle.
  - Clears done, error and words_loaded; word_index restarts at 0.
- start in LEN_HI, LEN_LO or DATA is ignored.
- Boundaries:
  - LEN=DEPTH is legal and fills the memory. Last address = (DEPTH-1)*4.
  - word_index never exceeds DEPTH-1.
  - Bytes offered in DONE or ERROR are not accepted (in_ready=0).

Test Plan:
1. Reset, start, stream 00 02 | 24 08 00 05 | AC 08 00 00 with in_valid held high -> imem_we pulses exactly twice:
   - 0x24080005 at address 0x0, then 0xAC080000 at address 0x4.
   - The pulses are 4 cycles apart; the first follows byte 5's handshake by 1 cycle.
   - done=1 and words_loaded=2; cpu_reset falls one cycle after done rises.
2. Same stream with in_valid randomly deasserted (stalls of 1-5 cycles) and start pulses inserted mid-DATA -> identical write sequence, final state, and word values.
3. Stream 00 00 -> DONE directly after byte 1; zero imem_we pulses; cpu_reset=0 from the 2nd DONE cycle.
4. ADDR_WIDTH=2, stream 00 05 -> ERROR, error=1, in_ready=0, cpu_reset stays 1, no writes. Then start with 00 04 + 16 bytes -> four writes at 0x0/0x4/0x8/0xC, done=1, error=0.
5. Assert reset after 6 data bytes of a 3-word load -> only one write occurred; outputs at reset values. A fresh start loads correctly from address 0.
6. After DONE, pulse start and load 00 01 | 00 00 00 00 -> cpu_reset goes 1 the next cycle; one write of 0x00000000 at 0x0; done reasserts and words_loaded=1.
